// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong ball engine.
package pong_pkg;

  localparam logic [3:0] FIELD_MAX = 4'd15;
  localparam logic [3:0] CENTER_X  = 4'd7;
  localparam logic [3:0] CENTER_Y  = 4'd7;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } dir_t;

  // Magnitude of a signed 5-bit speed, saturated to 15 (-16 maps to 15).
  function automatic logic [3:0] speed_mag(input logic [4:0] speed);
    logic [4:0] a;
    a = speed[4] ? (~speed + 5'd1) : speed;
    return a[4] ? 4'd15 : a[3:0];
  endfunction

endpackage

// File: rtl/ball_step_timer.sv
// Step-rate timer: converts the signed speed (and optional hit bonus level)
// into a one-cycle step pulse every (16 - |speed| - level) * PERIOD_SCALE clocks.
module ball_step_timer
  import pong_pkg::*;
#(
  parameter int PERIOD_SCALE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] speed,
  input  logic [1:0] level,
  output logic       step
);

  localparam int CW = 16;

  logic [3:0]    mag;
  logic [4:0]    base_units;
  logic [4:0]    bonus;
  logic [4:0]    units;
  logic [CW-1:0] period;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;
  logic          primed;

  // An unprimed counter (after reset or while frozen) behaves as if loaded
  // with the current period, so leaving speed 0 always starts a full period.
  always_comb begin
    mag        = speed_mag(speed);
    base_units = 5'd16 - {1'b0, mag};
    bonus      = {3'b000, level};
    units      = (base_units > bonus) ? (base_units - bonus) : 5'd1;
    period     = CW'(units) * CW'(PERIOD_SCALE);
    cnt_eff    = primed ? cnt : period;
    step       = primed && (cnt == '0) && (speed != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (speed == '0) begin
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      cnt    <= (cnt_eff == '0) ? (period - CW'(1)) : (cnt_eff - CW'(1));
    end
  end

endmodule

// File: rtl/pong_ball.sv
// Pong ball engine: position/direction registers, wall and paddle bounces, out flags.
// Optional feature macro BALL_ACCEL_EN: paddle hits shorten the step period.
module pong_ball
  import pong_pkg::*;
#(
  parameter int PERIOD_SCALE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [4:0] speed,
  input  logic [15:0]       lpaddle,
  input  logic [15:0]       rpaddle,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic              out_left,
  output logic              out_right
);

  dir_t       dx, dy, ndx, ndy;
  logic [3:0] nx, ny;
  logic       miss_l, miss_r;
  logic       step, advance;
  logic [1:0] level;

  ball_step_timer #(.PERIOD_SCALE(PERIOD_SCALE)) u_timer (
    .clk   (clk),
    .reset (reset),
    .speed (speed),
    .level (level),
    .step  (step)
  );

  assign advance = step && !(out_left || out_right);

  // Vertical move first: the paddle lookup uses the row the ball lands on.
  always_comb begin
    ndy    = dy;
    ndx    = dx;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (dy == POS && y == FIELD_MAX) begin
      ny  = FIELD_MAX - 4'd1;
      ndy = NEG;
    end else if (dy == NEG && y == 4'd0) begin
      ny  = 4'd1;
      ndy = POS;
    end else begin
      ny = (dy == POS) ? (y + 4'd1) : (y - 4'd1);
    end

    if (dx == NEG && x == 4'd1) begin
      if (lpaddle[ny]) begin
        nx  = 4'd2;
        ndx = POS;
      end else begin
        nx     = 4'd0;
        miss_l = 1'b1;
      end
    end else if (dx == POS && x == FIELD_MAX - 4'd1) begin
      if (rpaddle[ny]) begin
        nx  = FIELD_MAX - 4'd2;
        ndx = NEG;
      end else begin
        nx     = FIELD_MAX;
        miss_r = 1'b1;
      end
    end else begin
      nx = (dx == POS) ? (x + 4'd1) : (x - 4'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= CENTER_X;
      y         <= CENTER_Y;
      dx        <= POS;
      dy        <= POS;
      out_left  <= 1'b0;
      out_right <= 1'b0;
    end else if (advance) begin
      x         <= nx;
      y         <= ny;
      dx        <= ndx;
      dy        <= ndy;
      out_left  <= miss_l;
      out_right <= miss_r;
    end
  end

`ifdef BALL_ACCEL_EN
  logic [3:0] hits;
  logic       hit;

  assign hit = advance &&
               ((dx == NEG && x == 4'd1 && lpaddle[ny]) ||
                (dx == POS && x == FIELD_MAX - 4'd1 && rpaddle[ny]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits <= 4'd0;
    end else if (hit && hits != 4'd15) begin
      hits <= hits + 4'd1;
    end
  end

  assign level = hits[3:2];
`else
  assign level = 2'd0;
`endif

endmodule

// File: tb/tb_pong_ball.sv
// Bench for pong_ball: directed trajectories with hand-computed positions plus
// randomized speed/paddle/reset stimulus checked every cycle against a behavioural model.
module tb_pong_ball;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [4:0] speed;
  logic [15:0]       lpaddle;
  logic [15:0]       rpaddle;
  logic [3:0]        x;
  logic [3:0]        y;
  logic              out_left;
  logic              out_right;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pong_ball #(.PERIOD_SCALE(16)) dut (
    .clk       (clk),
    .reset     (rst),
    .speed     (speed),
    .lpaddle   (lpaddle),
    .rpaddle   (rpaddle),
    .x         (x),
    .y         (y),
    .out_left  (out_left),
    .out_right (out_right)
  );

  // ---------------- behavioural model ----------------
  int  mx, my, mdx, mdy, mhits, due;
  bit  mol, mor, fresh;
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;

  function automatic int period_of(input logic signed [4:0] s, input int h);
    int v, mag, units;
    v   = s;
    mag = (v < 0) ? -v : v;
    if (mag > 15) mag = 15;
    units = 16 - mag;
`ifdef BALL_ACCEL_EN
    units = units - h / 4;
    if (units < 1) units = 1;
`else
    if (h < 0) units = 1;
`endif
    return units * 16;
  endfunction

  function void model_move();
    int nx, ny;
    ny = my + mdy;
    if (ny > 15) begin ny = 14; mdy = -1; end
    else if (ny < 0) begin ny = 1; mdy = 1; end
    nx = mx + mdx;
    if (nx == 0) begin
      if (lpaddle[ny]) begin nx = 2; mdx = 1; if (mhits < 15) mhits++; end
      else mol = 1;
    end else if (nx == 15) begin
      if (rpaddle[ny]) begin nx = 13; mdx = -1; if (mhits < 15) mhits++; end
      else mor = 1;
    end
    mx = nx;
    my = ny;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mx = 7; my = 7; mdx = 1; mdy = 1;
      mol = 0; mor = 0; fresh = 1; mhits = 0; due = 0;
    end else begin
      if (speed == 5'sd0) begin
        fresh = 1;
      end else if (fresh) begin
        fresh = 0;
        due   = period_of(speed, mhits);
      end else begin
        due--;
        if (due == 0) begin
          due = period_of(speed, mhits);
          if (!(mol || mor)) model_move();
        end
      end
      exp_q.push_back({mol, mor, 4'(mx), 4'(my)});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check("reset_state", {out_left, out_right, x, y}, {2'b00, 4'd7, 4'd7});
    end else if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("model", {out_left, out_right, x, y}, exp_v);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic expect_pos(input string name, input int ex, input int ey, input bit el, input bit er);
    check(name, {out_left, out_right, x, y}, {el, er, 4'(ex), 4'(ey)});
  endtask

  // Count clock edges until the ball position changes; bounded.
  task automatic wait_move(output int edges);
    logic [7:0] start;
    start = {x, y};
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while ({x, y} == start && edges < 400);
    if ({x, y} == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_move: no step within %0d edges", edges);
    end
  endtask

  function automatic logic signed [4:0] pick_speed();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 5'sd0;
    if (r == 1) return 5'b10000;
    if (r <= 3) return 5'($urandom_range(0, 31));
    return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(12, 15)) : -5'($urandom_range(12, 15));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int exp_fast;
    rst = 1'b1;
    speed = 5'sd15;
    lpaddle = 16'hFFFF;
    rpaddle = 16'hFFFF;

    // First step, right paddle hit, top and bottom wall bounces.
    do_reset();
    repeat (16) @(posedge clk);
    #1 expect_pos("before_first_step", 7, 7, 0, 0);
    @(posedge clk); #1 expect_pos("first_step", 8, 8, 0, 0);
    repeat (16 * 7) @(posedge clk);
    #1 expect_pos("right_paddle_hit", 13, 15, 0, 0);
    repeat (16) @(posedge clk);
    #1 expect_pos("top_wall", 12, 14, 0, 0);
    repeat (16 * 14) @(posedge clk);
    #1 expect_pos("reach_row0", 4, 0, 0, 0);
    repeat (16) @(posedge clk);
    #1 expect_pos("bottom_wall", 5, 1, 0, 0);

    // Frozen at speed 0, then -16 behaves as 15.
    speed = 5'sd0;
    do_reset();
    repeat (200) @(posedge clk);
    #1 expect_pos("speed0_frozen", 7, 7, 0, 0);
    @(negedge clk) speed = 5'b10000;
    repeat (16) @(posedge clk);
    #1 expect_pos("neg16_wait", 7, 7, 0, 0);
    @(posedge clk); #1 expect_pos("neg16_step", 8, 8, 0, 0);

    // Right paddle miss: out_right and frozen position.
    speed = 5'sd15;
    rpaddle = 16'h0060;
    do_reset();
    repeat (1 + 16 * 8) @(posedge clk);
    #1 expect_pos("right_miss", 15, 15, 0, 1);
    repeat (50) @(posedge clk);
    #1 expect_pos("right_miss_held", 15, 15, 0, 1);

    // Left paddle miss, then asynchronous reset mid-period.
    rpaddle = 16'hFFFF;
    lpaddle = 16'hFFFB;
    do_reset();
    repeat (1 + 16 * 21) @(posedge clk);
    #1 expect_pos("left_miss", 0, 2, 1, 0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 expect_pos("async_reset", 7, 7, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Step interval at speed 11 before and after four paddle hits.
    lpaddle = 16'hFFFF;
    speed = 5'sd11;
    do_reset();
    wait_move(e);
    wait_move(e);
    check("period_speed11", e, 80);
    repeat (45) wait_move(e);
    wait_move(e);
    wait_move(e);
`ifdef BALL_ACCEL_EN
    exp_fast = 64;
`else
    exp_fast = 80;
`endif
    check("period_after_hits", e, exp_fast);

    // Randomized speed, paddles and resets against the model.
    do_reset();
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      lpaddle = 16'($urandom | $urandom);
      rpaddle = 16'($urandom | $urandom);
      if ($urandom_range(0, 99) == 0) speed = pick_speed();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
